score_display: RTL

Parametrised score keeper and on-screen score renderer for the VGA table-tennis game. It holds PLAYERS decimal scores of DIGITS BCD digits each and detects the winning score. It renders all scores as scaled 3×5 glyphs into a single-bit `score_scan` layer, which the video mixer ORs with the ball and paddle layers. It generalises the fixed two-player, two-digit score keeper with:

- configurable player count, digit count, position and pixel scale
- leading-zero blanking
- win detection
- blinking of the winner's field

---
 rtl/score_display.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//
// Score keeper and score-layer renderer for the VGA table-tennis game.
// Keeps PLAYERS decimal (BCD) scores of DIGITS digits each. Each rising edge
// on a player's score_add bit counts once, and the count saturates at all
// nines. The first score to reach WIN_SCORE latches winner/game_over and
// freezes the scores. All fields are drawn as scaled 3x5 glyphs into a
// one-bit layer that the video mixer ORs with the other layers.
//
// Ports
//   clk          pixel clock, all logic on posedge
//   reset_n      synchronous active-low reset
//   realx/realy  current pixel coordinates (10 bit each)
//   score_add    per-player increment request (level, counted on rising edge)
//   score_clear  synchronous clear of scores, winner and game_over
//   scores       packed BCD scores, player p at [(p+1)*DIGITS*4-1 : p*DIGITS*4]
//   winner       one-hot winner (several bits on a tie), 0 while no winner
//   game_over    high while a winner exists
//   score_scan   glyph pixel; valid two edges after the edge sampling x/y
// -----------------------------------------------------------------------------
module score_display #(
    parameter int                  PLAYERS    = 2,
    parameter int                  DIGITS     = 2,
    parameter int                  SCALE_LOG2 = 2,
    parameter int                  XSTART     = 224,
    parameter int                  YSTART     = 48,
    parameter int                  GAP        = 2,
    parameter logic [DIGITS*4-1:0] WIN_SCORE  = 8'h11,
    parameter bit                  LZBLANK    = 1'b1,
    parameter int                  BLINK_LOG2 = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [9:0]                    realx,
    input  logic [9:0]                    realy,
    input  logic [PLAYERS-1:0]            score_add,
    input  logic                          score_clear,
    output logic [PLAYERS*DIGITS*4-1:0]   scores,
    output logic [PLAYERS-1:0]            winner,
    output logic                          game_over,
    output logic                          score_scan
);

    localparam int FW     = DIGITS * 4;
    localparam int NCELL  = PLAYERS * DIGITS;
    localparam int CELL_W = 4 << SCALE_LOG2;
    localparam int CELL_H = 5 << SCALE_LOG2;

    // BCD +1 with ripple carry; an all-nines value is returned unchanged.
    function automatic logic [FW-1:0] bcd_inc(input logic [FW-1:0] v);
        logic [FW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            r = v;
        end
        return r;
    endfunction

    // Glyph rows packed top row first, 3 bits per row, MSB = leftmost column.
    function automatic logic [14:0] font(input logic [3:0] d);
        case (d)
            4'd0:    return 15'b111_101_101_101_111;
            4'd1:    return 15'b110_010_010_010_111;
            4'd2:    return 15'b111_001_111_100_111;
            4'd3:    return 15'b111_001_011_001_111;
            4'd4:    return 15'b101_101_111_001_001;
            4'd5:    return 15'b111_100_111_001_111;
            4'd6:    return 15'b111_100_111_101_111;
            4'd7:    return 15'b111_001_001_001_001;
            4'd8:    return 15'b111_101_111_101_111;
            4'd9:    return 15'b111_101_111_001_111;
            default: return 15'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Score keeping
    // ------------------------------------------------------------------
    logic [PLAYERS-1:0] add_q;
    logic [PLAYERS-1:0] add_prev_q;
    logic [PLAYERS-1:0] add_rise;
    logic [FW-1:0]      score_q   [PLAYERS];
    logic [FW-1:0]      score_inc [PLAYERS];
    logic [PLAYERS-1:0] win_match;
    logic [PLAYERS-1:0] winner_q;
    logic               game_over_q;

    assign add_rise = add_q & ~add_prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_player
            assign score_inc[gi]         = bcd_inc(score_q[gi]);
            assign win_match[gi]         = (score_q[gi] == WIN_SCORE);
            assign scores[gi*FW +: FW]   = score_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            add_q      <= '0;
            add_prev_q <= '0;
        end else begin
            add_q      <= score_add;
            add_prev_q <= add_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || score_clear) begin
            for (int p = 0; p < PLAYERS; p++) begin
                score_q[p] <= '0;
            end
            winner_q    <= '0;
            game_over_q <= 1'b0;
        end else if (!game_over_q) begin
            for (int p = 0; p < PLAYERS; p++) begin
                if (add_rise[p]) begin
                    score_q[p] <= score_inc[p];
                end
            end
            // Match is taken on the registered scores, so the win flags
            // trail the score update by one cycle; ties latch together.
            if (|win_match) begin
                winner_q    <= win_match;
                game_over_q <= 1'b1;
            end
        end
    end

    assign winner    = winner_q;
    assign game_over = game_over_q;

    // ------------------------------------------------------------------
    // Frame counter, advanced on arrival at pixel (0,0)
    // ------------------------------------------------------------------
    logic                at_origin;
    logic                at_origin_q;
    logic [BLINK_LOG2:0] frame_cnt_q;

    assign at_origin = (realx == 10'd0) && (realy == 10'd0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            at_origin_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            at_origin_q <= at_origin;
            if (at_origin && !at_origin_q) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Render pipeline: stage 1 samples coordinates, stage 2 resolves the
    // cell/row/column/digit, stage 3 looks up the glyph bit.
    // ------------------------------------------------------------------
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [10:0] y_off;
    logic        row_hit;

    assign y_off   = {1'b0, y_q} - 11'(YSTART);
    assign row_hit = ({1'b0, y_q} >= 11'(YSTART)) && (y_off < 11'(CELL_H));

    logic [NCELL-1:0] cell_hit;
    logic [NCELL-1:0] cell_blank;
    logic [1:0]       cell_col [NCELL];
    logic [3:0]       cell_dig [NCELL];

    // Cell bounds are compile-time constants, so each cell is a pair of
    // comparators against x; no division or run-time multiply is needed.
    generate
        for (gi = 0; gi < NCELL; gi++) begin : g_cell
            localparam int P  = gi / DIGITS;
            localparam int D  = gi % DIGITS;
            localparam int CX = XSTART + P * (DIGITS + GAP) * CELL_W + D * CELL_W;
            logic [10:0] x_off;
            logic        lz;
            logic        blink;
            assign x_off        = {1'b0, x_q} - 11'(CX);
            assign cell_hit[gi] = ({1'b0, x_q} >= 11'(CX)) && (x_off < 11'(CELL_W));
            assign cell_col[gi] = 2'(x_off >> SCALE_LOG2);
            assign cell_dig[gi] = score_q[P][(DIGITS-1-D)*4 +: 4];
            // Leading zero: this digit and every more-significant one is 0.
            assign lz           = LZBLANK && (D != DIGITS - 1)
                                  && (score_q[P][FW-1 -: (D+1)*4] == '0);
            assign blink        = game_over_q && winner_q[P] && frame_cnt_q[BLINK_LOG2];
            assign cell_blank[gi] = lz || blink;
        end
    endgenerate

    logic       hit_d, hit_q;
    logic [1:0] col_d, col_q;
    logic [2:0] row_d, row_q;
    logic [3:0] dig_d, dig_q;

    always_comb begin
        hit_d = 1'b0;
        col_d = 2'd0;
        dig_d = 4'd0;
        row_d = 3'(y_off >> SCALE_LOG2);
        for (int i = 0; i < NCELL; i++) begin
            if (cell_hit[i]) begin
                hit_d = row_hit && !cell_blank[i];
                col_d = cell_col[i];
                dig_d = cell_dig[i];
            end
        end
    end

    logic [14:0] glyph;
    logic [2:0]  glyph_row;
    logic        glyph_pix;

    assign glyph     = font(dig_q);
    assign glyph_row = 3'(glyph >> (3 * (4 - int'(row_q))));

    always_comb begin
        glyph_pix = 1'b0;
        case (col_q)
            2'd0:    glyph_pix = glyph_row[2];
            2'd1:    glyph_pix = glyph_row[1];
            2'd2:    glyph_pix = glyph_row[0];
            default: glyph_pix = 1'b0; // spacing column
        endcase
    end

    logic scan_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            hit_q  <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
            dig_q  <= '0;
            scan_q <= 1'b0;
        end else begin
            x_q    <= realx;
            y_q    <= realy;
            hit_q  <= hit_d;
            col_q  <= col_d;
            row_q  <= row_d;
            dig_q  <= dig_d;
            scan_q <= hit_q && glyph_pix;
        end
    end

    assign score_scan = scan_q;

endmodule
